// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back stage: the write/skid entry
// format and the occupancy states of the load tracker and skid buffer.
package wb_pkg;

  localparam int PW = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic          v;
    logic [PW-1:0] a;
    logic [DW-1:0] d;
  } wb_wr_t;

  // Encoding is {ld_pend, sk_v}, so each state bit is one occupancy flag
  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    LDP      = 2'b10,
    SKID     = 2'b01,
    LDP_SKID = 2'b11
  } wb_state_e;

endpackage

// File: rtl/wb_fwd_mux.sv
// Per-port operand bypass: picks the youngest in-flight write that matches
// the read address, falling back to the register file data.
module wb_fwd_mux
  import wb_pkg::*;
(
  input  wb_wr_t        sk,
  input  wb_wr_t        wr,
  input  logic [PW-1:0] rd_addr,
  input  logic [DW-1:0] rf_dat,
  output logic [DW-1:0] fwd
);

  // The skid entry is always younger than the write register contents
  always_comb begin
    fwd = rf_dat;
    if (sk.v && sk.a == rd_addr)
      fwd = sk.d;
    else if (wr.v && wr.a == rd_addr)
      fwd = wr.d;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges ALU results and one-cycle load returns into the
// register file write port, with a one-entry skid and operand forwarding.
//
// state    | meaning
// ---------+---------------------------------------------------------
// EMPTY    | no load return due, skid empty
// LDP      | load data arrives on mem_rdata this cycle
// SKID     | skid holds an ALU result waiting for the write port
// LDP_SKID | load data arriving and skid occupied
module wb_stage
  import wb_pkg::*;
#(
  parameter int pw = PW,
  parameter int dw = DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [pw-1:0] alu_dst,
  input  logic [dw-1:0] alu_data,
  input  logic          ld_req,
  input  logic [pw-1:0] ld_dst,
  input  logic [dw-1:0] mem_rdata,
  input  logic [pw-1:0] rd_addrA,
  input  logic [pw-1:0] rd_addrB,
  input  logic [dw-1:0] rf_datA,
  input  logic [dw-1:0] rf_datB,
  output logic          rf_wr_en,
  output logic [pw-1:0] rf_wr_addr,
  output logic [dw-1:0] rf_dat_in,
  output logic [dw-1:0] fwdA_out,
  output logic [dw-1:0] fwdB_out,
  output logic          stall
);

  wb_state_e     state_q, state_d;
  logic          ld_pend, sk_v;
  logic [pw-1:0] ld_a;
  logic [pw-1:0] sk_a;
  logic [dw-1:0] sk_dat;
  wb_wr_t        wr_q, wr_nxt, sk_view;
  logic          alu_acc, ld_acc;

  assign stall   = sk_v | (ld_pend & ((rd_addrA == ld_a) | (rd_addrB == ld_a)));
  assign alu_acc = alu_valid & ~stall;
  assign ld_acc  = ld_req & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // SKID always drains in one cycle: stall blocks new loads while it is full
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:    state_d = ld_acc ? LDP : EMPTY;
      LDP: begin
        if (alu_acc)
          state_d = ld_acc ? LDP_SKID : SKID;
        else
          state_d = ld_acc ? LDP : EMPTY;
      end
      SKID:     state_d = EMPTY;
      LDP_SKID: state_d = SKID;
      default:  state_d = EMPTY;
    endcase
  end

  always_comb begin
    ld_pend = 1'b0;
    sk_v    = 1'b0;
    case (state_q)
      LDP:      ld_pend = 1'b1;
      SKID:     sk_v    = 1'b1;
      LDP_SKID: begin
        ld_pend = 1'b1;
        sk_v    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_nxt = '0;
    if (ld_pend)
      wr_nxt = '{v: 1'b1, a: ld_a, d: mem_rdata};
    else if (sk_v)
      wr_nxt = '{v: 1'b1, a: sk_a, d: sk_dat};
    else if (alu_acc)
      wr_nxt = '{v: 1'b1, a: alu_dst, d: alu_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      ld_a   <= '0;
      sk_a   <= '0;
      sk_dat <= '0;
    end else begin
      wr_q <= wr_nxt;
      if (ld_acc)
        ld_a <= ld_dst;
      if (ld_pend && alu_acc) begin
        sk_a   <= alu_dst;
        sk_dat <= alu_data;
      end
    end
  end

  assign sk_view    = '{v: sk_v, a: sk_a, d: sk_dat};
  assign rf_wr_en   = wr_q.v;
  assign rf_wr_addr = wr_q.a;
  assign rf_dat_in  = wr_q.d;

  wb_fwd_mux u_fwd_a (
    .sk      (sk_view),
    .wr      (wr_q),
    .rd_addr (rd_addrA),
    .rf_dat  (rf_datA),
    .fwd     (fwdA_out)
  );

  wb_fwd_mux u_fwd_b (
    .sk      (sk_view),
    .wr      (wr_q),
    .rd_addr (rd_addrB),
    .rf_dat  (rf_datB),
    .fwd     (fwdB_out)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios then random traffic, checked against
// an in-order write queue model and a register file fed by the DUT.
module tb_wb_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid;
  logic [3:0] alu_dst;
  logic [7:0] alu_data;
  logic       ld_req;
  logic [3:0] ld_dst;
  logic [7:0] mem_rdata;
  logic [3:0] rd_addrA, rd_addrB;
  logic [7:0] rf_datA, rf_datB;
  logic       rf_wr_en;
  logic [3:0] rf_wr_addr;
  logic [7:0] rf_dat_in;
  logic [7:0] fwdA_out, fwdB_out;
  logic       stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_dst    (alu_dst),
    .alu_data   (alu_data),
    .ld_req     (ld_req),
    .ld_dst     (ld_dst),
    .mem_rdata  (mem_rdata),
    .rd_addrA   (rd_addrA),
    .rd_addrB   (rd_addrB),
    .rf_datA    (rf_datA),
    .rf_datB    (rf_datB),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_dat_in  (rf_dat_in),
    .fwdA_out   (fwdA_out),
    .fwdB_out   (fwdB_out),
    .stall      (stall)
  );

  // Register file driven only by the DUT write port
  logic [7:0] rf_mem [16] = '{default: 8'h00};
  always @(posedge clk)
    if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_dat_in;
  assign rf_datA = rf_mem[rd_addrA];
  assign rf_datB = rf_mem[rd_addrB];

  // Reference: program-ordered queue of ALU results awaiting the port,
  // loads take the port the cycle after their data returns.
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } ent_t;
  ent_t       q[$];
  logic       m_ld_pend;
  logic [3:0] m_ld_dst;
  logic       m_wr_v;
  logic [3:0] m_wr_a;
  logic [7:0] m_wr_d;
  logic [7:0] m_rf [16] = '{default: 8'h00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ld_pend = 1'b0;
    m_ld_dst  = 4'd0;
    m_wr_v    = 1'b0;
    m_wr_a    = 4'd0;
    m_wr_d    = 8'd0;
  endtask

  function automatic logic exp_stall();
    return (q.size() != 0) ||
           (m_ld_pend && (rd_addrA == m_ld_dst || rd_addrB == m_ld_dst));
  endfunction

  function automatic logic [7:0] exp_fwd(input logic [3:0] ra);
    logic [7:0] r;
    r = m_rf[ra];
    if (m_wr_v && m_wr_a == ra) r = m_wr_d;
    foreach (q[i]) if (q[i].a == ra) r = q[i].d;
    return r;
  endfunction

  task automatic set_in(input logic av, input logic [3:0] ad, input logic [7:0] adat,
                        input logic lr, input logic [3:0] ldd, input logic [7:0] mrd,
                        input logic [3:0] ra, input logic [3:0] rb);
    alu_valid = av;  alu_dst = ad;  alu_data = adat;
    ld_req = lr;     ld_dst = ldd;  mem_rdata = mrd;
    rd_addrA = ra;   rd_addrB = rb;
    #1;
  endtask

  task automatic check_model();
    check("stall", stall, exp_stall());
    check("wr_en", rf_wr_en, m_wr_v);
    if (m_wr_v) begin
      check("wr_addr", rf_wr_addr, m_wr_a);
      check("wr_data", rf_dat_in, m_wr_d);
    end
    check("fwdA", fwdA_out, exp_fwd(rd_addrA));
    check("fwdB", fwdB_out, exp_fwd(rd_addrB));
  endtask

  task automatic tick();
    logic st, acc_a, acc_l;
    ent_t e;
    st = exp_stall();
    @(posedge clk);
    if (m_wr_v) m_rf[m_wr_a] = m_wr_d;
    acc_a = alu_valid && !st;
    acc_l = ld_req && !st;
    if (acc_a) q.push_back('{a: alu_dst, d: alu_data});
    if (m_ld_pend) begin
      m_wr_v = 1'b1;  m_wr_a = m_ld_dst;  m_wr_d = mem_rdata;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      m_wr_v = 1'b1;  m_wr_a = e.a;  m_wr_d = e.d;
    end else begin
      m_wr_v = 1'b0;
    end
    m_ld_pend = acc_l;
    if (acc_l) m_ld_dst = ld_dst;
    #1;
  endtask

  task automatic step(input logic av, input logic [3:0] ad, input logic [7:0] adat,
                      input logic lr, input logic [3:0] ldd, input logic [7:0] mrd,
                      input logic [3:0] ra, input logic [3:0] rb);
    set_in(av, ad, adat, lr, ldd, mrd, ra, rb);
    check_model();
    tick();
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #10;
    check("rst_wr_en", rf_wr_en, 1'b0);
    check("rst_wr_addr", rf_wr_addr, 4'd0);
    check("rst_wr_data", rf_dat_in, 8'd0);
    check("rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU only
    step(1, 4'd3, 8'h5A, 0, 0, 0, 0, 1);
    set_in(0, 0, 0, 0, 0, 0, 4'd3, 0);
    check("alu_wr_en", rf_wr_en, 1'b1);
    check("alu_wr_addr", rf_wr_addr, 4'd3);
    check("alu_wr_data", rf_dat_in, 8'h5A);
    check("alu_stall", stall, 1'b0);
    check("alu_fwdA", fwdA_out, 8'h5A);
    check_model();
    tick();

    // Load with one-cycle load-use hazard
    step(0, 0, 0, 1, 4'd7, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 8'hC3, 4'd7, 0);
    check("ldu_stall", stall, 1'b1);
    check_model();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 4'd7, 0);
    check("ld_wr_addr", rf_wr_addr, 4'd7);
    check("ld_wr_data", rf_dat_in, 8'hC3);
    check("ld_stall_clr", stall, 1'b0);
    check("ld_fwdA", fwdA_out, 8'hC3);
    check_model();
    tick();

    // Collision into skid, then a held ALU op across the stall
    step(0, 0, 0, 1, 4'd2, 0, 0, 0);
    set_in(1, 4'd2, 8'h11, 0, 0, 8'h22, 0, 0);
    check("col_no_stall", stall, 1'b0);
    check_model();
    tick();
    set_in(1, 4'd5, 8'h77, 0, 0, 0, 4'd2, 0);
    check("col_wr_data", rf_dat_in, 8'h22);
    check("col_stall", stall, 1'b1);
    check("col_fwdA", fwdA_out, 8'h11);
    check_model();
    tick();
    set_in(1, 4'd5, 8'h77, 0, 0, 0, 4'd2, 0);
    check("skid_wr_addr", rf_wr_addr, 4'd2);
    check("skid_wr_data", rf_dat_in, 8'h11);
    check("skid_stall_clr", stall, 1'b0);
    check_model();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 4'd2, 4'd5);
    check("hold_wr_addr", rf_wr_addr, 4'd5);
    check("hold_wr_data", rf_dat_in, 8'h77);
    check("col_final_r2", rf_mem[2], 8'h11);
    check_model();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 4'd2, 4'd5);
    check("hold_once", rf_wr_en, 1'b0);
    check_model();
    tick();

    // Back-to-back loads
    step(0, 0, 0, 1, 4'd1, 0, 0, 0);
    step(0, 0, 0, 1, 4'd4, 8'hA1, 0, 0);
    set_in(0, 0, 0, 0, 0, 8'hA4, 0, 0);
    check("b2b_wr1", {rf_wr_en, rf_wr_addr, rf_dat_in}, {1'b1, 4'd1, 8'hA1});
    check("b2b_stall", stall, 1'b0);
    check_model();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check("b2b_wr2", {rf_wr_en, rf_wr_addr, rf_dat_in}, {1'b1, 4'd4, 8'hA4});
    check_model();
    tick();

    // Asynchronous reset one cycle after a load
    step(1, 4'd9, 8'h3C, 1, 4'd6, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 8'h5E, 4'd6, 0);
    check_model();
    #2 reset = 1'b1;
    #1;
    check("arst_wr_en", rf_wr_en, 1'b0);
    check("arst_wr_addr", rf_wr_addr, 4'd0);
    check("arst_stall", stall, 1'b0);
    check("arst_fwdA", fwdA_out, rf_mem[6]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    set_in(0, 0, 0, 0, 0, 8'h5E, 4'd6, 4'd9);
    check("post_rst_no_wr", rf_wr_en, 1'b0);
    check_model();
    tick();
    set_in(0, 0, 0, 0, 0, 8'h5E, 4'd6, 4'd9);
    check("post_rst_no_wr2", rf_wr_en, 1'b0);
    check_model();
    tick();

    // Random traffic on a small address window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 8'($urandom),
           1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)), 8'($urandom),
           4'($urandom_range(0, 5)), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 4'd15, 4'd15);
    for (int i = 0; i < 16; i++) check($sformatf("rf_final_%0d", i), rf_mem[i], m_rf[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
